// File: rtl/cache_pkg.sv
// Shared cache definitions: block/word geometry, address split and the write-back drain states.
// Keeps the data cache and its write-back buffer in agreement on how a block address is formed.
package cache_pkg;

    localparam int BLOCK_W    = 64;
    localparam int WORD_W     = 16;
    localparam int BEATS      = BLOCK_W / WORD_W;
    localparam int TAG_W      = 22;
    localparam int INDEX_W    = 8;
    localparam int BLK_ADRS_W = TAG_W + INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    // Block address is the word-granular part of a byte address.
    function automatic logic [BLK_ADRS_W-1:0] blk_adrs_of(input logic [31:0] byte_adrs);
        return byte_adrs[31:2];
    endfunction

endpackage

// File: rtl/wb_lookup_cam.sv
// Address CAM over the buffer entries: newest valid match wins, judged by the larger age rank.
// Latency: combinational. Backpressure: none, pure lookup.
// No-hit returns all-zero data so the refill path can OR it in without extra gating.
module wb_lookup_cam #(
    parameter int DEPTH  = 4,
    parameter int ADRS_W = 30,
    parameter int DATA_W = 64,
    parameter int AGE_W  = 2
) (
    input  logic [ADRS_W-1:0]       lookup_adrs,
    input  logic [DEPTH*ADRS_W-1:0] entry_adrs,
    input  logic [DEPTH*DATA_W-1:0] entry_data,
    input  logic [DEPTH-1:0]        entry_vld,
    input  logic [DEPTH*AGE_W-1:0]  entry_age,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        hit      = 1'b0;
        data     = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_adrs[i*ADRS_W +: ADRS_W] == lookup_adrs) &&
                (!hit || (entry_age[i*AGE_W +: AGE_W] > best_age))) begin
                hit      = 1'b1;
                best_age = entry_age[i*AGE_W +: AGE_W];
                data     = entry_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer: queues evicted dirty blocks and drains each as four word writes to memory.
// Latency: push visible to lookup next cycle; first memory request one cycle after the push edge.
// Backpressure: memory stalls via i_mem_ack; pushes into a full buffer are dropped (sticky overflow).
module cache_writeback_buffer #(
    parameter int DEPTH      = 4,
    parameter int BLK_ADRS_W = 30,
    parameter int BLOCK_W    = 64,
    parameter int WORD_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_write_back,
    input  logic [BLOCK_W-1:0]         i_write_back_block,
    input  logic [BLK_ADRS_W-1:0]      i_block_adrs,
    input  logic [BLK_ADRS_W-1:0]      i_lookup_adrs,
    output logic                       o_lookup_hit,
    output logic [BLOCK_W-1:0]         o_lookup_block,
    output logic                       o_mem_req,
    output logic [BLK_ADRS_W+1:0]      o_mem_adrs,
    output logic [WORD_W-1:0]          o_mem_data,
    input  logic                       i_mem_ack,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    import cache_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [BLK_ADRS_W-1:0] adrs_mem [DEPTH];
    logic [BLOCK_W-1:0]    blk_mem  [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;

    drain_state_t state, state_nxt;
    logic [1:0]   beat, beat_nxt;
    logic         mem_req;

    logic full;
    logic pop;
    logic push_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop     = (state == SEND) && i_mem_ack && (beat == LAST_BEAT);
    // A final-beat ack frees a slot on the same edge, so a full buffer can still accept.
    assign push_ok = i_write_back && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                adrs_mem[i] <= '0;
                blk_mem[i]  <= '0;
            end
        end else if (push_ok) begin
            adrs_mem[wr_ptr] <= i_block_adrs;
            blk_mem[wr_ptr]  <= i_write_back_block;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (i_write_back && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = SEND;
                    beat_nxt  = '0;
                end
            end
            SEND: begin
                mem_req = 1'b1;
                if (i_mem_ack) begin
                    beat_nxt = beat + 2'd1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    assign o_mem_req  = mem_req;
    assign o_mem_adrs = mem_req ? {adrs_mem[rd_ptr], beat} : '0;
    assign o_mem_data = mem_req ? blk_mem[rd_ptr][int'(beat)*WORD_W +: WORD_W] : '0;

    assign o_full     = full;
    assign o_empty    = (count == '0);
    assign o_count    = count;
    assign o_overflow = overflow;

    // Entry age is its distance from the read pointer; valid entries are those younger than count.
    logic [DEPTH-1:0]            ent_vld;
    logic [DEPTH*PW-1:0]         ent_age;
    logic [DEPTH*BLK_ADRS_W-1:0] ent_adrs;
    logic [DEPTH*BLOCK_W-1:0]    ent_blk;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] rank;
        assign rank                              = PW'(i) - rd_ptr;
        assign ent_vld[i]                        = ({1'b0, rank} < count);
        assign ent_age[i*PW +: PW]               = rank;
        assign ent_adrs[i*BLK_ADRS_W +: BLK_ADRS_W] = adrs_mem[i];
        assign ent_blk[i*BLOCK_W +: BLOCK_W]     = blk_mem[i];
    end

    wb_lookup_cam #(
        .DEPTH  (DEPTH),
        .ADRS_W (BLK_ADRS_W),
        .DATA_W (BLOCK_W),
        .AGE_W  (PW)
    ) u_lookup_cam (
        .lookup_adrs (i_lookup_adrs),
        .entry_adrs  (ent_adrs),
        .entry_data  (ent_blk),
        .entry_vld   (ent_vld),
        .entry_age   (ent_age),
        .hit         (o_lookup_hit),
        .data        (o_lookup_block)
    );

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Bench for cache_writeback_buffer: queue-level reference model with a scoreboard of memory beats,
// directed scenarios followed by random push/ack/probe traffic.
module tb_cache_writeback_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb = 1'b0;
    logic [63:0] wb_blk = '0;
    logic [29:0] blk_adrs = '0;
    logic [29:0] lk_adrs = '0;
    logic        mem_ack = 1'b0;
    logic        lk_hit;
    logic [63:0] lk_blk;
    logic        mem_req;
    logic [31:0] mem_adrs;
    logic [15:0] mem_data;
    logic        full, empty, overflow;
    logic [2:0]  count;

    cache_writeback_buffer #(.DEPTH(DEPTH), .BLK_ADRS_W(30), .BLOCK_W(64), .WORD_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_write_back(wb), .i_write_back_block(wb_blk), .i_block_adrs(blk_adrs),
        .i_lookup_adrs(lk_adrs), .o_lookup_hit(lk_hit), .o_lookup_block(lk_blk),
        .o_mem_req(mem_req), .o_mem_adrs(mem_adrs), .o_mem_data(mem_data), .i_mem_ack(mem_ack),
        .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] adrs; logic [63:0] blk; } ent_t;
    typedef struct { logic [31:0] adrs; logic [15:0] data; } beat_t;

    ent_t  mq[$];      // pending blocks, oldest first
    beat_t exp_q[$];   // memory beats still owed, in order
    beat_t wr_log[$];  // beats the DUT actually wrote
    bit    m_send = 0;
    int    m_beat = 0;
    bit    m_ovf = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a block queue plus the drain progress of its head.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_send = 0;
            m_beat = 0;
            m_ovf  = 0;
        end else begin
            bit pop, acc, start;
            ent_t e;
            beat_t b;
            pop   = m_send && mem_ack && (m_beat == 3);
            acc   = wb && ((mq.size() < DEPTH) || pop);
            start = !m_send && (mq.size() > 0);
            if (wb && !acc) m_ovf = 1;
            if (m_send && mem_ack) begin
                if (m_beat == 3) begin
                    void'(mq.pop_front());
                    m_send = 0;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (start) begin
                m_send = 1;
                m_beat = 0;
            end
            if (acc) begin
                e.adrs = blk_adrs;
                e.blk  = wb_blk;
                mq.push_back(e);
                for (int k = 0; k < 4; k++) begin
                    b.adrs = {blk_adrs, 2'(k)};
                    b.data = wb_blk[16*k +: 16];
                    exp_q.push_back(b);
                end
            end
        end
    end

    function automatic logic [64:0] model_lookup(input logic [29:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].adrs == a) return {1'b1, mq[i].blk};
        return '0;
    endfunction

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        logic [64:0] lk;
        beat_t b;
        chk("mem_req", mem_req, m_send);
        chk("count", count, mq.size());
        chk("count_le_depth", count <= DEPTH, 1);
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("overflow", overflow, m_ovf);
        lk = model_lookup(lk_adrs);
        chk("lookup_hit", lk_hit, lk[64]);
        chk("lookup_block", lk_blk, lk[63:0]);
        if (mem_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                chk("mem_adrs", mem_adrs, exp_q[0].adrs);
                chk("mem_data", mem_data, exp_q[0].data);
                if (mem_ack) begin
                    b.adrs = mem_adrs;
                    b.data = mem_data;
                    wr_log.push_back(b);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        wb  = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic push(input logic [29:0] a, input logic [63:0] d);
        wb = 1'b1;
        blk_adrs = a;
        wb_blk = d;
        tick();
        wb = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((mq.size() != 0 || m_send) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        logic [31:0] a_hold;
        logic [15:0] d_hold;
        int n, sz;

        // Reset state
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_adrs", mem_adrs, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_lk_block", lk_blk, 0);
        do_reset();

        // Single block drained with ack held high
        mem_ack = 1'b1;
        push(30'h5, 64'h0004_0003_0002_0001);
        wait_idle(40);
        tick();
        chk("t1_nbeats", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            chk("t1_adrs", wr_log[k].adrs, 32'h14 + 32'(k));
            chk("t1_data", wr_log[k].data, 16'(k + 1));
        end
        chk("t1_empty", empty, 1);
        chk("t1_count", count, 0);

        // Fill, overflow, then drain in order
        do_reset();
        for (int k = 0; k < 4; k++) push(30'h10 + 30'(k), {$urandom, $urandom});
        chk("t2_full", full, 1);
        push(30'h1F, 64'hDEAD);
        chk("t2_overflow", overflow, 1);
        chk("t2_count", count, 4);
        mem_ack = 1'b1;
        wait_idle(100);
        tick();
        chk("t2_nbeats", wr_log.size(), 16);
        for (int k = 0; k < 4 && 4*k < wr_log.size(); k++)
            chk("t2_order", wr_log[4*k].adrs, {30'h10 + 30'(k), 2'b00});

        // Full buffer, push coincides with final-beat ack
        do_reset();
        for (int k = 0; k < 4; k++) push(30'h20 + 30'(k), {$urandom, $urandom});
        mem_ack = 1'b1;
        n = 0;
        while (!(m_send && m_beat == 3) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("t3_timeout", 1, 0);
        push(30'h2F, 64'h1111_2222_3333_4444);
        chk("t3_count", count, 4);
        chk("t3_overflow", overflow, 0);
        wait_idle(100);
        tick();
        chk("t3_nbeats", wr_log.size(), 20);
        if (wr_log.size() == 20) begin
            chk("t3_last_adrs", wr_log[16].adrs, {30'h2F, 2'b00});
            chk("t3_last_data", wr_log[19].data, 16'h1111);
        end

        // Duplicate addresses: newest wins
        do_reset();
        push(30'h9, 64'hAAAA_AAAA_AAAA_AAAA);
        push(30'h9, 64'hBBBB_BBBB_BBBB_BBBB);
        lk_adrs = 30'h9;
        #1;
        chk("t4_hit", lk_hit, 1);
        chk("t4_block", lk_blk, 64'hBBBB_BBBB_BBBB_BBBB);
        lk_adrs = 30'hA;
        #1;
        chk("t4_miss_hit", lk_hit, 0);
        chk("t4_miss_block", lk_blk, 0);

        // Stall stability then reset mid-burst
        do_reset();
        push(30'h3, 64'h0D0C_0B0A_0908_0706);
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        chk("t5_req", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        a_hold = mem_adrs;
        d_hold = mem_data;
        chk("t5_beat1_adrs", a_hold, {30'h3, 2'd1});
        chk("t5_beat1_data", d_hold, 16'h0908);
        repeat (3) begin
            tick();
            chk("t5_stable_adrs", mem_adrs, a_hold);
            chk("t5_stable_data", mem_data, d_hold);
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_empty", empty, 1);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        sz = wr_log.size();
        repeat (10) tick();
        chk("t5_no_more", wr_log.size(), sz);

        // Random traffic
        do_reset();
        repeat (3000) begin
            wb       = ($urandom_range(0, 99) < 30);
            blk_adrs = 30'($urandom_range(0, 7));
            wb_blk   = {$urandom, $urandom};
            lk_adrs  = 30'($urandom_range(0, 7));
            mem_ack  = ($urandom_range(0, 99) < 60);
            tick();
        end
        wb = 1'b0;
        mem_ack = 1'b1;
        wait_idle(200);
        tick();
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_writeback_buffer.md
# cache_writeback_buffer

Write-back buffer downstream of the 4-way pseudo-LRU data cache. It captures each evicted dirty 64-bit block, together with its block address, into a small FIFO. It drains the FIFO to main memory as four 16-bit word writes over a req/ack handshake. A combinational lookup port lets the cache refill path read a block that is still pending in the buffer instead of stale memory.

## Interface
- DEPTH, 4, number of block entries (power of two, ≥2)
- BLK_ADRS_W, 30, block address width (tag 22 + index 8 = byte/word address [31:2])
- BLOCK_W, 64, evicted block width
- WORD_W, 16, memory word width; BLOCK_W/WORD_W = 4 beats
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_write_back  in  1  push strobe (cache o_write_back)
- i_write_back_block  in  64  evicted block (cache o_write_back_block); bits [15:0] = offset 0
- i_block_adrs  in  30  block address of the evicted line
- i_lookup_adrs  in  30  refill-path probe address
- o_lookup_hit  out  1  probe matches a valid entry
- o_lookup_block  out  64  data of matching entry; 0 when no hit
- o_mem_req  out  1  memory write request, current beat
- o_mem_adrs  out  32  {entry address, beat[1:0]}
- o_mem_data  out  16  beat word
- i_mem_ack  in  1  memory accepted current beat (sampled at posedge)
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_count  out  $clog2(DEPTH)+1  valid entries
- o_overflow  out  1  sticky: a push was dropped

## Operation
- FIFO: storage arrays for address and block, plus wr_ptr, rd_ptr, and count. The pointers wrap modulo DEPTH.
- Push: when i_write_back=1 and (not full, or a pop happens on the same edge), the entry is written at wr_ptr and wr_ptr increments.
- Push while full with no same-edge pop: the entry is dropped, o_overflow is set, and it stays set until rst.
- Duplicate addresses are never merged; each push is a separate entry.
- Drain FSM states:
  - IDLE: o_mem_req=0. If count>0, go to SEND with beat=0.
  - SEND: o_mem_req=1. o_mem_adrs={adrs[rd_ptr], beat}. o_mem_data=block[rd_ptr][16*beat+15:16*beat]. On i_mem_ack, beat increments.
  - On ack of beat 3, pop (rd_ptr increments, count decrements) and go to IDLE.
- Beat order is 0,1,2,3, i.e. bits [15:0] first.
- o_mem_adrs and o_mem_data are held stable while o_mem_req=1 and ack=0. There is no timeout.
- Lookup is purely combinational. It compares i_lookup_adrs against all valid entries, including the one being drained. If several entries match, the newest (closest to wr_ptr) wins.
- count update: +1 on accepted push, -1 on pop, unchanged on both or neither.

## Timing
- Reset values: o_mem_req=0, o_mem_adrs=0, o_mem_data=0, o_full=0, o_empty=1, o_count=0, o_overflow=0, o_lookup_hit=0, o_lookup_block=0. FSM=IDLE, pointers=0, beat=0.
- Push at edge N: o_empty falls and o_lookup_hit is valid after edge N. FSM enters SEND at edge N+1, so o_mem_req rises in cycle N+1.
- Minimum 5 cycles per block (1 IDLE + 4 single-cycle acked beats). Back-to-back blocks therefore have one IDLE cycle between them.
- Full with push and final-beat ack on the same edge: push accepted, count unchanged, o_overflow stays 0.
- Empty with push: no same-cycle bypass to the memory port.
- rst asserted mid-burst: o_mem_req drops immediately, and the partial block and all entries are discarded. Memory must tolerate a partial block.
- Pushes during rst are ignored.

## Structure
- Shared package `cache_pkg`: BLOCK_W, WORD_W, BEATS=4, TAG_W=22, INDEX_W=8, the drain-state enum {IDLE, SEND}, and the block-address slice helper, so the cache and this buffer agree on the address split.
- One sub-module, `wb_lookup_cam`: the DEPTH-way address compare with newest-wins priority select. It is combinational and takes valid/age vectors as inputs.

## Test plan
- Reset, then push block 64'h0004_0003_0002_0001 at adrs 30'h5 with i_mem_ack tied 1 → beats at o_mem_adrs 0x14,0x15,0x16,0x17 with data 1,2,3,4. Then o_empty=1 and o_count=0.
- Push 4 blocks with ack=0 → o_full=1. A fifth push sets o_overflow=1 and o_count stays 4. Releasing ack drains all 4 in push order.
- With a full buffer, push on the edge that acks beat 3 → o_count stays 4 and o_overflow=0. The new block is drained last.
- Push adrs 30'h9 twice, with data A then B; probe 30'h9 → o_lookup_hit=1, o_lookup_block=B. Probe 30'hA → hit=0, block=0.
- Hold ack=0 for 3 cycles on beat 1 → o_mem_adrs and o_mem_data stable. Assert rst mid-burst → o_mem_req=0 in the same cycle, o_empty=1, then no further requests.
- Random push/ack traffic against a reference queue model → memory write sequence identical to the model; o_count always ≤ DEPTH.
